// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage: instruction-fetch stage with a decoupled memory port,
// an in-order prefetch queue of {pc, instr}, and redirect/flush handling.
// Stale responses that belong to requests issued before a redirect are
// counted and silently discarded when they come back.
module if_prefetch_stage #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] instruction_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus_4_out
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [XLEN-1:0] pc_mem_q [DEPTH];
    logic [XLEN-1:0] instr_mem_q [DEPTH];

    logic [CW:0]     occupancy;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_target;
    logic            unused_redirect_lsbs;

    // Credit counts only registered state so a same-cycle pop never frees a slot early.
    assign occupancy       = {1'b0, count_q} + {1'b0, inflight_q};
    assign imem_req_valid  = !rst && (occupancy < (CW + 1)'(DEPTH)) && !redirect_valid;
    assign imem_req_addr   = fetch_pc_q;
    assign req_fire        = imem_req_valid && imem_req_ready;

    assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign push = imem_resp_valid && (drop_q == '0) && !redirect_valid;
    assign id_valid = (count_q != '0);
    assign pop  = id_valid && id_ready && !redirect_valid;

    assign instruction_out = instr_mem_q[head_q];
    assign pc_out          = pc_mem_q[head_q];
    assign pc_plus_4_out   = pc_out + XLEN'(4);

    // Next-state: a redirect overrides issue, response and pop bookkeeping.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            resp_pc_d  = redirect_target;
            inflight_d = inflight_q - CW'(imem_resp_valid);
            drop_d     = inflight_q - CW'(imem_resp_valid);
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            inflight_d = inflight_q + CW'(req_fire) - CW'(imem_resp_valid);
            if (imem_resp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
                tail_d    = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control registers: PCs, counters and queue pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Queue storage; cleared on reset so the head outputs read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[tail_q]    <= resp_pc_q;
            instr_mem_q[tail_q] <= imem_resp_data;
        end
    end

    // The issue credit must make a push into a full queue impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        push |-> (count_q != CW'(DEPTH)));

endmodule

// File: tb/tb_if_prefetch_stage.sv
// tb_if_prefetch_stage: directed scenarios for the prefetch stage against a
// fixed-latency in-order memory model that answers with a known word per address.
module tb_if_prefetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_4_out;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t pending[$];
    int   lat;
    int   cyc;
    int   accepted;
    int   checks;
    int   failures;

    if_prefetch_stage #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .pc_plus_4_out   (pc_plus_4_out)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    // Hold reset for two edges, then release just after an edge; that cycle is cycle 0.
    task automatic doReset(input int l);
        rst             = 1'b1;
        lat             = l;
        pending.delete();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b1;
        id_ready        = 1'b1;
        accepted        = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    // Start of a cycle: the memory presents whatever response is due now.
    task automatic beginCycle();
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
        if (pending.size() > 0 && pending[0].due == cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memData(pending[0].addr);
            void'(pending.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    endtask

    // Mid-cycle: outputs are settled, so record any accepted request.
    task automatic sampleCycle();
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            pending.push_back('{addr: imem_req_addr, due: cyc + lat});
            accepted++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_req: valid=%b addr=%h expected valid=0 addr=00000000", imem_req_valid, imem_req_addr);
        end
        checks++;
        if (id_valid !== 1'b0 || instruction_out !== 32'h0 || pc_out !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_head: id_valid=%b instr=%h pc=%h expected 0/0/0", id_valid, instruction_out, pc_out);
        end
        checks++;
        if (pc_plus_4_out !== 32'h4) begin
            failures++;
            $display("[TB] FAIL reset_pc4: got %h expected 00000004", pc_plus_4_out);
        end
    endtask

    task automatic test_stream();
        doReset(1);
        for (int c = 0; c < 7; c++) begin
            if (c > 0) beginCycle();
            sampleCycle();
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * c)) begin
                failures++;
                $display("[TB] FAIL stream_req c%0d: valid=%b addr=%h expected 1/%h", c, imem_req_valid, imem_req_addr, 32'(4 * c));
            end
            if (c < 2) begin
                checks++;
                if (id_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL stream_early c%0d: id_valid=%b expected 0", c, id_valid);
                end
            end else begin
                checks++;
                if (id_valid !== 1'b1 || pc_out !== 32'(4 * (c - 2))) begin
                    failures++;
                    $display("[TB] FAIL stream_pc c%0d: valid=%b pc=%h expected 1/%h", c, id_valid, pc_out, 32'(4 * (c - 2)));
                end
                checks++;
                if (instruction_out !== memData(32'(4 * (c - 2))) || pc_plus_4_out !== 32'(4 * (c - 1))) begin
                    failures++;
                    $display("[TB] FAIL stream_data c%0d: instr=%h pc4=%h expected %h/%h", c, instruction_out, pc_plus_4_out, memData(32'(4 * (c - 2))), 32'(4 * (c - 1)));
                end
            end
        end
    endtask

    task automatic test_stall();
        doReset(1);
        id_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) beginCycle();
            id_ready = 1'b0;
            sampleCycle();
        end
        checks++;
        if (accepted !== 4 || imem_req_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_credit: accepted=%0d valid=%b expected 4/0", accepted, imem_req_valid);
        end
        for (int k = 0; k < 5; k++) begin
            beginCycle();
            id_ready = 1'b1;
            sampleCycle();
            checks++;
            if (id_valid !== 1'b1 || pc_out !== 32'(4 * k) || instruction_out !== memData(32'(4 * k))) begin
                failures++;
                $display("[TB] FAIL stall_drain k%0d: valid=%b pc=%h instr=%h expected 1/%h/%h", k, id_valid, pc_out, instruction_out, 32'(4 * k), memData(32'(4 * k)));
            end
            if (k == 0) begin
                checks++;
                if (imem_req_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL stall_nocredit: valid=%b expected 0", imem_req_valid);
                end
            end
            if (k == 1) begin
                checks++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
                    failures++;
                    $display("[TB] FAIL stall_resume: valid=%b addr=%h expected 1/00000010", imem_req_valid, imem_req_addr);
                end
            end
        end
    endtask

    task automatic test_req_stall();
        doReset(1);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) beginCycle();
            imem_req_ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            sampleCycle();
            if (c >= 2 && c <= 5) begin
                checks++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
                    failures++;
                    $display("[TB] FAIL reqstall_hold c%0d: valid=%b addr=%h expected 1/00000008", c, imem_req_valid, imem_req_addr);
                end
            end
            if (c == 6) begin
                checks++;
                if (imem_req_addr !== 32'hC) begin
                    failures++;
                    $display("[TB] FAIL reqstall_next: addr=%h expected 0000000c", imem_req_addr);
                end
            end
            if (c == 5) begin
                checks++;
                if (id_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL reqstall_bubble: id_valid=%b expected 0", id_valid);
                end
            end
            if (c == 7) begin
                checks++;
                if (id_valid !== 1'b1 || pc_out !== 32'h8 || instruction_out !== memData(32'h8)) begin
                    failures++;
                    $display("[TB] FAIL reqstall_noskip: valid=%b pc=%h instr=%h expected 1/00000008/%h", id_valid, pc_out, instruction_out, memData(32'h8));
                end
            end
        end
    endtask

    task automatic test_redirect();
        doReset(3);
        for (int c = 0; c < 9; c++) begin
            if (c > 0) beginCycle();
            if (c == 2) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h103;
            end
            sampleCycle();
            if (c == 2) begin
                checks++;
                if (imem_req_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL redir_noissue: valid=%b expected 0", imem_req_valid);
                end
            end
            if (c == 3) begin
                checks++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
                    failures++;
                    $display("[TB] FAIL redir_target: valid=%b addr=%h expected 1/00000100", imem_req_valid, imem_req_addr);
                end
            end
            if (c >= 3 && c <= 6) begin
                checks++;
                if (id_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL redir_stale c%0d: id_valid=%b pc=%h expected id_valid 0", c, id_valid, pc_out);
                end
            end
            if (c >= 7) begin
                checks++;
                if (id_valid !== 1'b1 || pc_out !== 32'(32'h100 + 4 * (c - 7)) || instruction_out !== memData(32'(32'h100 + 4 * (c - 7)))) begin
                    failures++;
                    $display("[TB] FAIL redir_first c%0d: valid=%b pc=%h instr=%h expected 1/%h/%h", c, id_valid, pc_out, instruction_out, 32'(32'h100 + 4 * (c - 7)), memData(32'(32'h100 + 4 * (c - 7))));
                end
            end
        end
    endtask

    task automatic test_redirect_collide();
        doReset(2);
        for (int c = 0; c < 9; c++) begin
            if (c > 0) beginCycle();
            if (c == 3) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h200;
            end
            sampleCycle();
            if (c == 3) begin
                checks++;
                if (id_valid !== 1'b1 || pc_out !== 32'h0 || imem_resp_valid !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL collide_setup: valid=%b pc=%h resp=%b expected 1/00000000/1", id_valid, pc_out, imem_resp_valid);
                end
            end
            if (c == 4) begin
                checks++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
                    failures++;
                    $display("[TB] FAIL collide_target: valid=%b addr=%h expected 1/00000200", imem_req_valid, imem_req_addr);
                end
            end
            if (c >= 4 && c <= 6) begin
                checks++;
                if (id_valid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL collide_empty c%0d: id_valid=%b pc=%h expected id_valid 0", c, id_valid, pc_out);
                end
            end
            if (c >= 7) begin
                checks++;
                if (id_valid !== 1'b1 || pc_out !== 32'(32'h200 + 4 * (c - 7)) || instruction_out !== memData(32'(32'h200 + 4 * (c - 7)))) begin
                    failures++;
                    $display("[TB] FAIL collide_first c%0d: valid=%b pc=%h instr=%h expected 1/%h/%h", c, id_valid, pc_out, instruction_out, 32'(32'h200 + 4 * (c - 7)), memData(32'(32'h200 + 4 * (c - 7))));
                end
            end
        end
    endtask

    task automatic test_wrap();
        doReset(1);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) beginCycle();
            if (c == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'hFFFF_FFFE;
            end
            sampleCycle();
            if (c == 2) begin
                checks++;
                if (imem_req_addr !== 32'h0) begin
                    failures++;
                    $display("[TB] FAIL wrap_fetch: addr=%h expected 00000000", imem_req_addr);
                end
            end
            if (c == 3) begin
                checks++;
                if (id_valid !== 1'b1 || pc_out !== 32'hFFFF_FFFC || pc_plus_4_out !== 32'h0) begin
                    failures++;
                    $display("[TB] FAIL wrap_pc4: valid=%b pc=%h pc4=%h expected 1/fffffffc/00000000", id_valid, pc_out, pc_plus_4_out);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        doReset(1);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) beginCycle();
            sampleCycle();
        end
        checks++;
        if (id_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL arst_pre: id_valid=%b expected 1", id_valid);
        end
        beginCycle();
        #2;
        rst = 1'b1;
        pending.delete();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        #1;
        checks++;
        if (id_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || pc_out !== 32'h0) begin
            failures++;
            $display("[TB] FAIL arst_now: id_valid=%b req_valid=%b addr=%h pc=%h expected 0/0/0/0", id_valid, imem_req_valid, imem_req_addr, pc_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) beginCycle();
            sampleCycle();
            if (c == 0) begin
                checks++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
                    failures++;
                    $display("[TB] FAIL arst_restart: valid=%b addr=%h expected 1/00000000", imem_req_valid, imem_req_addr);
                end
            end
            if (c == 2) begin
                checks++;
                if (id_valid !== 1'b1 || pc_out !== 32'h0 || instruction_out !== memData(32'h0)) begin
                    failures++;
                    $display("[TB] FAIL arst_first: valid=%b pc=%h instr=%h expected 1/00000000/%h", id_valid, pc_out, instruction_out, memData(32'h0));
                end
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        clk             = 1'b0;
        rst             = 1'b1;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        id_ready        = 1'b1;
        checks          = 0;
        failures        = 0;
        cyc             = 0;
        lat             = 1;
        accepted        = 0;
        #12;
        test_reset();
        test_stream();
        test_stall();
        test_req_stall();
        test_redirect();
        test_redirect_collide();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_prefetch_stage.md
# if_prefetch_stage

Parametrised instruction-fetch stage with a decoupled instruction-memory request/response port, a DEPTH-entry prefetch queue, and redirect/flush support. It owns the fetch PC and issues in-order word fetches to a memory of arbitrary latency. Returned instructions are buffered together with their PCs and handed to decode through a valid/ready handshake. Stale responses after a redirect are discarded, so the pipeline can stall and take branches without losing or duplicating instructions.

## Interface
- XLEN, riscv_pkg::XLEN (32): data/address width.
- DEPTH, 4: prefetch queue entries (≥2, power of two); also the maximum number of requests outstanding plus buffered.
- RESET_PC, 0: first fetch address after reset.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  XLEN  word address of the request; bits [1:0] are always 0.
- imem_resp_valid  in  1  one response, strictly in request order; no backpressure.
- imem_resp_data  in  XLEN  instruction word.
- redirect_valid  in  1  flush and restart fetch (branch/jump/trap).
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] are ignored (treated as 0).
- id_valid  out  1  queue head valid.
- id_ready  in  1  decode consumes the head (low = stall).
- instruction_out  out  XLEN  head instruction.
- pc_out  out  XLEN  head PC.
- pc_plus_4_out  out  XLEN  pc_out + 4, modulo 2^XLEN.

## Operation
- State:
  - fetch_pc: next request address.
  - resp_pc: PC of the next live response.
  - inflight: outstanding requests.
  - drop_cnt: stale outstanding requests.
  - Queue of {pc, instr} with count.
  - Counters are $clog2(DEPTH+1) bits wide.
- Issue:
  - imem_req_valid = (count + inflight < DEPTH) && !redirect_valid, using registered values only; no same-cycle pop credit.
  - imem_req_addr = fetch_pc.
  - On handshake, fetch_pc += 4 (wraps) and inflight increments.
  - While ready is low, addr and valid stay stable unless a redirect occurs.
- Response, no redirect this cycle:
  - inflight decrements.
  - If drop_cnt > 0: discard the data and decrement drop_cnt.
  - Otherwise: push {resp_pc, data} and resp_pc += 4.
  - The credit rule guarantees the queue never overflows. A push into a full queue is a design error and is flagged by an assertion.
- Pop: when id_valid && id_ready, the head is removed. Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority):
  - Queue is emptied (count = 0) and any same-cycle pop is void.
  - fetch_pc and resp_pc are loaded with {redirect_pc[XLEN-1:2], 2'b00}.
  - No request is issued this cycle.
  - A response arriving this cycle is discarded.
  - drop_cnt is loaded with inflight − imem_resp_valid, which marks every remaining outstanding request stale, including any already-stale ones.
  - Back-to-back redirects are legal; the last one wins.
- Outputs are driven directly from the queue head registers; there is no combinational path from imem_resp_* to id_*.

## Timing
- Reset values:
  - imem_req_valid = 0 while rst is high.
  - imem_req_addr = RESET_PC.
  - id_valid = 0.
  - instruction_out = 0, pc_out = 0, pc_plus_4_out = 4 (queue storage is cleared).
  - All counters = 0.
- First request is issued in the first cycle after rst deasserts, provided imem_req_ready = 1.
- Latency from response to visibility is 1 cycle: a response in cycle N gives id_valid in N+1.
- With a 1-cycle memory: request in cycle 0, response in cycle 1, id_valid in cycle 2.
- Sustained throughput is 1 instruction/cycle when the memory latency is below DEPTH cycles.
- Redirect takes effect in the cycle it is asserted. id_valid = 0 in the following cycle, and the first request to the target is issued that following cycle.
- Reset asserted mid-operation returns all state to reset values immediately, regardless of clk. Responses to pre-reset requests are the memory's responsibility to squash.

## Test plan
- Reset, then 1-cycle memory with id_ready = 1 → requests to 0, 4, 8…; id_valid from cycle 2; pc_out = 0, 4, 8 on consecutive cycles; pc_plus_4_out = pc_out + 4.
- id_ready = 0 with DEPTH = 4 → exactly 4 requests accepted, then imem_req_valid = 0. Release id_ready → 4 instructions drain in order, then fetch resumes at 0x10.
- imem_req_ready = 0 for 3 cycles → imem_req_addr stays 0x8 with valid held; no PC skip.
- 3-cycle memory, 2 requests in flight, redirect to 0x103 → addr 0x100 next cycle; the 2 stale responses are dropped; first id_valid shows pc_out = 0x100 with the data returned for 0x100.
- Redirect in the same cycle as a response and a pop → response discarded, queue empty, drop_cnt = inflight − 1; no duplicated or lost instruction.
- rst pulsed asynchronously between edges mid-stream → id_valid = 0 and imem_req_valid = 0 immediately; after release, fetch restarts at RESET_PC.
